// File: rtl/reg_index_scanner_pkg.sv
// rtl/reg_index_scanner_pkg.sv - shared sizes, FSM encoding and constants for reg_index_scanner
package reg_index_scanner_pkg;

  localparam int WORD_LENGTH_DEF = 32;
  localparam int BITS_DEF        = 5;

  // Hardwired register; its index is dropped at load when SKIP_REG0_EN is defined
  localparam int REG_ZERO = 0;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/reg_index_scanner_lowest_set_index.sv
// rtl/reg_index_scanner_lowest_set_index.sv - combinational find-first-set over a register mask
module lowest_set_index
  import reg_index_scanner_pkg::*;
#(
  parameter int WORD_LENGTH = WORD_LENGTH_DEF,
  parameter int BITS        = BITS_DEF
) (
  input  logic [WORD_LENGTH-1:0] i_mask,
  output logic [BITS-1:0]        o_index,
  output logic                   o_any_set
);

  // Walk from the top down so the last hit written is the lowest set bit
  always_comb begin
    o_index = '0;
    for (int i = WORD_LENGTH - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_index = BITS'(i);
      end
    end
  end

  assign o_any_set = |i_mask;

endmodule

// File: rtl/reg_index_scanner.sv
// rtl/reg_index_scanner.sv - serialises a register mask into indices, lowest first
// Optional: SKIP_REG0_EN drops register zero from the loaded mask.
module reg_index_scanner
  import reg_index_scanner_pkg::*;
#(
  parameter int WORD_LENGTH = WORD_LENGTH_DEF,
  parameter int BITS        = BITS_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Start_i,
  input  logic [WORD_LENGTH-1:0] Request_i,
  input  logic                   Ready_i,
  output logic [BITS-1:0]        Index_o,
  output logic                   Valid_o,
  output logic                   Busy_o,
  output logic                   Done_o,
  output logic [BITS:0]          Count_o
);

  state_t                 r_state;
  logic [WORD_LENGTH-1:0] r_pending;
  logic [BITS:0]          r_count;

  state_t                 w_next_state;
  logic [WORD_LENGTH-1:0] w_next_pending;
  logic [BITS:0]          w_next_count;
  logic [WORD_LENGTH-1:0] w_load_mask;
  logic [WORD_LENGTH-1:0] w_onehot;
  logic [WORD_LENGTH-1:0] w_cleared;
  logic [BITS-1:0]        w_index;
  logic                   w_any_set;
  logic                   w_valid;
  logic                   w_done;

`ifdef SKIP_REG0_EN
  assign w_load_mask = Request_i & ~({{(WORD_LENGTH-1){1'b0}}, 1'b1} << REG_ZERO);
`else
  assign w_load_mask = Request_i;
`endif

  lowest_set_index #(
    .WORD_LENGTH (WORD_LENGTH),
    .BITS        (BITS)
  ) u_lowest_set_index (
    .i_mask    (r_pending),
    .o_index   (w_index),
    .o_any_set (w_any_set)
  );

  assign w_onehot  = {{(WORD_LENGTH-1){1'b0}}, 1'b1} << w_index;
  assign w_cleared = r_pending & ~w_onehot;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_count   <= '0;
    end else begin
      r_state   <= w_next_state;
      r_pending <= w_next_pending;
      r_count   <= w_next_count;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_next_pending = r_pending;
    w_next_count   = r_count;
    w_valid        = 1'b0;
    w_done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (Start_i) begin
          w_next_pending = w_load_mask;
          w_next_count   = '0;
          w_next_state   = (|w_load_mask) ? SCAN : DONE;
        end
      end
      SCAN: begin
        w_valid = w_any_set;
        if (!w_any_set) begin
          w_next_state = DONE;
        end else if (Ready_i) begin
          w_next_pending = w_cleared;
          w_next_count   = r_count + (BITS+1)'(1);
          if (w_cleared == '0) begin
            w_next_state = DONE;
          end
        end
      end
      DONE: begin
        w_done       = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign Valid_o = w_valid;
  assign Index_o = w_valid ? w_index : '0;
  assign Busy_o  = (r_state != IDLE);
  assign Done_o  = w_done;
  assign Count_o = r_count;

endmodule

// File: tb/tb_reg_index_scanner.sv
// tb/tb_reg_index_scanner.sv - directed, table-driven checks for reg_index_scanner
module tb_reg_index_scanner;

  logic        clk;
  logic        reset;
  logic        Start_i;
  logic [31:0] Request_i;
  logic        Ready_i;
  logic [4:0]  Index_o;
  logic        Valid_o;
  logic        Busy_o;
  logic        Done_o;
  logic [5:0]  Count_o;

  int checks;
  int errors;

  reg_index_scanner #(
    .WORD_LENGTH (32),
    .BITS        (5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Start_i   (Start_i),
    .Request_i (Request_i),
    .Ready_i   (Ready_i),
    .Index_o   (Index_o),
    .Valid_o   (Valid_o),
    .Busy_o    (Busy_o),
    .Done_o    (Done_o),
    .Count_o   (Count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] req;
    int          stall;
    int          exp_count;
    int          exp_first;
    int          exp_last;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_scan(input logic [31:0] req, input int stall, input int exp_count,
                          input int exp_first, input int exp_last, input bit mid_start);
    int q[$];
    for (int b = 0; b < 32; b++) begin
`ifdef SKIP_REG0_EN
      if (req[b] && b != 0) q.push_back(b);
`else
      if (req[b]) q.push_back(b);
`endif
    end
    @(negedge clk);
    Start_i   = 1'b1;
    Request_i = req;
    Ready_i   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    Start_i   = 1'b0;
    Request_i = req ^ 32'h5A5A_0F0F;
    for (int j = 0; j < q.size(); j++) begin
      if (j == 0) begin
        for (int s = 0; s < stall; s++) begin
          check("stall_valid", 32'(Valid_o), 32'd1);
          check("stall_index", 32'(Index_o), 32'(exp_first));
          @(posedge clk);
          @(negedge clk);
        end
      end
      if (mid_start && j == 10) begin
        Start_i   = 1'b1;
        Request_i = 32'h0000_0001;
      end
      Ready_i = 1'b1;
      check("scan_valid", 32'(Valid_o), 32'd1);
      check("scan_index", 32'(Index_o), 32'(q[j]));
      check("scan_count", 32'(Count_o), 32'(j));
      check("scan_busy", 32'(Busy_o), 32'd1);
      if (j == 0) check("first_index", 32'(Index_o), 32'(exp_first));
      if (j == q.size() - 1) check("last_index", 32'(Index_o), 32'(exp_last));
      @(posedge clk);
      @(negedge clk);
      Start_i = 1'b0;
      Ready_i = 1'b0;
    end
    check("done_pulse", 32'(Done_o), 32'd1);
    check("done_valid", 32'(Valid_o), 32'd0);
    check("done_index", 32'(Index_o), 32'd0);
    check("done_busy", 32'(Busy_o), 32'd1);
    check("done_count", 32'(Count_o), 32'(exp_count));
    @(posedge clk);
    @(negedge clk);
    check("idle_done", 32'(Done_o), 32'd0);
    check("idle_busy", 32'(Busy_o), 32'd0);
    check("idle_count", 32'(Count_o), 32'(exp_count));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    Start_i   = 1'b0;
    Request_i = 32'h0;
    Ready_i   = 1'b0;

    vecs[0] = '{32'h8000_0012, 0, 3, 1, 31};
    vecs[1] = '{32'h0000_0100, 5, 1, 8, 8};
    vecs[2] = '{32'h0000_0000, 0, 0, -1, -1};
    vecs[3] = '{32'h8000_0000, 2, 1, 31, 31};
`ifdef SKIP_REG0_EN
    vecs[4] = '{32'h0000_0003, 0, 1, 1, 1};
    vecs[5] = '{32'h0000_0001, 0, 0, -1, -1};
    vecs[6] = '{32'hA5A5_A5A5, 1, 15, 2, 31};
`else
    vecs[4] = '{32'h0000_0003, 0, 2, 0, 1};
    vecs[5] = '{32'h0000_0001, 3, 1, 0, 0};
    vecs[6] = '{32'hA5A5_A5A5, 1, 16, 0, 31};
`endif

    #1;
    check("rst_valid", 32'(Valid_o), 32'd0);
    check("rst_index", 32'(Index_o), 32'd0);
    check("rst_busy", 32'(Busy_o), 32'd0);
    check("rst_done", 32'(Done_o), 32'd0);
    check("rst_count", 32'(Count_o), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 7; v++) begin
      run_scan(vecs[v].req, vecs[v].stall, vecs[v].exp_count,
               vecs[v].exp_first, vecs[v].exp_last, 1'b0);
    end

`ifdef SKIP_REG0_EN
    run_scan(32'hFFFF_FFFF, 0, 31, 1, 31, 1'b1);
`else
    run_scan(32'hFFFF_FFFF, 0, 32, 0, 31, 1'b1);
`endif

    @(negedge clk);
    Start_i   = 1'b1;
    Request_i = 32'h0000_0070;
    Ready_i   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    Start_i = 1'b0;
    Ready_i = 1'b1;
    check("pre_rst_index4", 32'(Index_o), 32'd4);
    @(posedge clk);
    @(negedge clk);
    Ready_i = 1'b0;
    check("pre_rst_index5", 32'(Index_o), 32'd5);
    check("pre_rst_count", 32'(Count_o), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", 32'(Valid_o), 32'd0);
    check("arst_index", 32'(Index_o), 32'd0);
    check("arst_busy", 32'(Busy_o), 32'd0);
    check("arst_done", 32'(Done_o), 32'd0);
    check("arst_count", 32'(Count_o), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("post_rst_done", 32'(Done_o), 32'd0);
      check("post_rst_busy", 32'(Busy_o), 32'd0);
    end
    run_scan(32'h8000_0012, 0, 3, 1, 31, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
